// File: rtl/cpu_pkg.sv
// Shared encodings for the EX-stage branch resolver and its 2-bit direction table.
package cpu_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;
    localparam logic [2:0] BR_JAL  = 3'd7;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Word-aligned table index: pc[idx_w+1:2]. Callers zero-extend the PC to 64 bits.
    function automatic int unsigned bht_index(input logic [63:0] pc, input int unsigned idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((pc >> 2) & mask);
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational read, one clocked write.
module bht_2bit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] wr_cur;
    logic [1:0] wr_nxt;

    // No write-to-read bypass: a same-cycle read sees the pre-update counter.
    assign rd_ctr_o = cnt_q[rd_idx_i];
    assign wr_cur   = cnt_q[wr_idx_i];

    always_comb begin
        wr_nxt = wr_cur;
        if (wr_taken_i && (wr_cur != ST)) begin
            wr_nxt = wr_cur + 2'd1;
        end else if (!wr_taken_i && (wr_cur != SNT)) begin
            wr_nxt = wr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                cnt_q[i] <= WNT;
            end
        end else if (we_i) begin
            cnt_q[wr_idx_i] <= wr_nxt;
        end
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// EX-stage branch/JAL resolver: compares outcome with the IF prediction, redirects on mispredict.
module branch_predict_resolve
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             if_pred_taken_o,
    input  logic             ex_valid_i,
    input  logic             ex_stall_i,
    input  logic [2:0]       ex_br_type_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [XLEN-1:0]  ex_src1_i,
    input  logic [XLEN-1:0]  ex_src2_i,
    input  logic [XLEN-1:0]  ex_target_i,
    input  logic             ex_pred_taken_i,
    output logic             br_taken_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] perf_branches_o,
    output logic [CNT_W-1:0] perf_mispredicts_o
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       if_ctr;
    logic             eff;
    logic             bht_we;
    logic             taken;
    logic [CNT_W-1:0] branches_d, branches_q;
    logic [CNT_W-1:0] mispredicts_d, mispredicts_q;

    assign if_idx = IDX_W'(bht_index(64'(if_pc_i), IDX_W));
    assign ex_idx = IDX_W'(bht_index(64'(ex_pc_i), IDX_W));

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (if_idx),
        .rd_ctr_o   (if_ctr),
        .we_i       (bht_we),
        .wr_idx_i   (ex_idx),
        .wr_taken_i (taken)
    );

    assign if_pred_taken_o = if_ctr[1];

    assign eff = ex_valid_i & ~ex_stall_i & (ex_br_type_i != BR_NONE);

    always_comb begin
        taken = 1'b0;
        unique case (ex_br_type_i)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = (ex_src1_i == ex_src2_i);
            BR_BNE:  taken = (ex_src1_i != ex_src2_i);
            BR_BLT:  taken = ($signed(ex_src1_i) < $signed(ex_src2_i));
            BR_BGE:  taken = ($signed(ex_src1_i) >= $signed(ex_src2_i));
            BR_BLTU: taken = (ex_src1_i < ex_src2_i);
            BR_BGEU: taken = (ex_src1_i >= ex_src2_i);
            BR_JAL:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        if (!ex_valid_i) begin
            taken = 1'b0;
        end
    end

    assign br_taken_o    = taken;
    assign redirect_o    = eff & (taken != ex_pred_taken_i);
    assign redirect_pc_o = taken ? ex_target_i : (ex_pc_i + XLEN'(4));

    // JAL is always taken and carries no direction history.
    assign bht_we = eff & (ex_br_type_i != BR_JAL);

    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (eff && (branches_q != '1)) begin
            branches_d = branches_q + 1'b1;
        end
        if (redirect_o && (mispredicts_q != '1)) begin
            mispredicts_d = mispredicts_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign perf_branches_o    = branches_q;
    assign perf_mispredicts_o = mispredicts_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: vector table plus BHT, stall and saturation sequences.
module tb_branch_predict_resolve;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [XLEN-1:0]  if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic             ex_stall;
    logic [2:0]       ex_br_type;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_src1;
    logic [XLEN-1:0]  ex_src2;
    logic [XLEN-1:0]  ex_target;
    logic             ex_pred_taken;
    logic             br_taken;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] perf_branches;
    logic [CNT_W-1:0] perf_mispredicts;

    int errors = 0;
    int checks = 0;
    int m_br   = 0;
    int m_mis  = 0;

    branch_predict_resolve #(
        .XLEN      (XLEN),
        .BHT_DEPTH (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .if_pc_i            (if_pc),
        .if_pred_taken_o    (if_pred_taken),
        .ex_valid_i         (ex_valid),
        .ex_stall_i         (ex_stall),
        .ex_br_type_i       (ex_br_type),
        .ex_pc_i            (ex_pc),
        .ex_src1_i          (ex_src1),
        .ex_src2_i          (ex_src2),
        .ex_target_i        (ex_target),
        .ex_pred_taken_i    (ex_pred_taken),
        .br_taken_o         (br_taken),
        .redirect_o         (redirect),
        .redirect_pc_o      (redirect_pc),
        .perf_branches_o    (perf_branches),
        .perf_mispredicts_o (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] pc;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] tgt;
        logic        pred;
        logic        exp_eff;
        logic        exp_taken;
        logic        exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic st, input logic [2:0] t, input logic [31:0] pc,
                         input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] tgt,
                         input logic pred);
        ex_valid      = v;
        ex_stall      = st;
        ex_br_type    = t;
        ex_pc         = pc;
        ex_src1       = s1;
        ex_src2       = s2;
        ex_target     = tgt;
        ex_pred_taken = pred;
        #1;
    endtask

    // Clock one edge and advance the saturating counter model.
    task automatic tick(input logic eff, input logic mis);
        @(posedge clk);
        #1;
        if (eff && m_br < 15) m_br++;
        if (mis && m_mis < 15) m_mis++;
    endtask

    task automatic check_perf(input string name);
        check({name, ".branches"}, 64'(perf_branches), 64'(m_br));
        check({name, ".mispredicts"}, 64'(perf_mispredicts), 64'(m_mis));
    endtask

    task automatic pred_at(input string name, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(name, 64'(if_pred_taken), 64'(exp));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{3'd1, 32'h40, 32'd5, 32'd5, 32'h80, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80};
        vecs[1]  = '{3'd3, 32'h44, 32'hFFFFFFFF, 32'd1, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1000};
        vecs[2]  = '{3'd5, 32'h48, 32'hFFFFFFFF, 32'd1, 32'h2000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4C};
        vecs[3]  = '{3'd4, 32'h4C, 32'hFFFFFFFF, 32'd1, 32'h2400, 1'b1, 1'b1, 1'b0, 1'b1, 32'h50};
        vecs[4]  = '{3'd6, 32'h50, 32'hFFFFFFFF, 32'd1, 32'h3000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h3000};
        vecs[5]  = '{3'd2, 32'h54, 32'd3, 32'd4, 32'h60, 1'b1, 1'b1, 1'b1, 1'b0, 32'h60};
        vecs[6]  = '{3'd2, 32'h58, 32'd7, 32'd7, 32'h90, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5C};
        vecs[7]  = '{3'd1, 32'h5C, 32'd1, 32'd2, 32'h94, 1'b1, 1'b1, 1'b0, 1'b1, 32'h60};
        vecs[8]  = '{3'd0, 32'h60, 32'd9, 32'd9, 32'h90, 1'b1, 1'b0, 1'b0, 1'b0, 32'h64};
        vecs[9]  = '{3'd7, 32'h64, 32'd0, 32'd0, 32'h800, 1'b1, 1'b1, 1'b1, 1'b0, 32'h800};
        vecs[10] = '{3'd4, 32'h68, 32'd5, 32'd5, 32'h70, 1'b0, 1'b1, 1'b1, 1'b1, 32'h70};
        vecs[11] = '{3'd5, 32'h6C, 32'd0, 32'hFFFFFFFF, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100};
        vecs[12] = '{3'd2, 32'hFFFFFFFC, 32'd1, 32'd1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

        rst   = 1'b1;
        if_pc = 32'h0;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_perf("reset");
        pred_at("reset.pred40", 32'h40, 1'b0);

        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 1'b0, vecs[i].typ, vecs[i].pc, vecs[i].s1, vecs[i].s2, vecs[i].tgt,
                  vecs[i].pred);
            check($sformatf("vec%0d.taken", i), 64'(br_taken), 64'(vecs[i].exp_taken));
            check($sformatf("vec%0d.redirect", i), 64'(redirect), 64'(vecs[i].exp_redir));
            check($sformatf("vec%0d.rpc", i), 64'(redirect_pc), 64'(vecs[i].exp_rpc));
            tick(vecs[i].exp_eff, vecs[i].exp_redir);
            check_perf($sformatf("vec%0d", i));
        end
        idle();

        // Four taken beq at 0x100 (idx 0); aliased read at 0x200 during the first one.
        if_pc = 32'h200;
        drive(1'b1, 1'b0, 3'd1, 32'h100, 32'd1, 32'd1, 32'h140, 1'b1);
        check("alias.same_cycle", 64'(if_pred_taken), 64'd0);
        tick(1'b1, 1'b0);
        check("alias.next_cycle", 64'(if_pred_taken), 64'd1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        idle();
        pred_at("sat.top.pred", 32'h100, 1'b1);

        // Not-taken walk-down 11->10->01->00->00, then 00->01 shows no underflow wrap.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 3'd1, 32'h100, 32'd1, 32'd2, 32'h140, 1'b0);
            check($sformatf("nt%0d.rpc", i), 64'(redirect_pc), 64'h104);
            check($sformatf("nt%0d.taken", i), 64'(br_taken), 64'd0);
            tick(1'b1, 1'b0);
            idle();
            pred_at($sformatf("nt%0d.pred", i), 32'h100, (i == 0) ? 1'b1 : 1'b0);
        end
        drive(1'b1, 1'b0, 3'd1, 32'h100, 32'd1, 32'd1, 32'h140, 1'b0);
        tick(1'b1, 1'b1);
        idle();
        pred_at("sat.bottom.pred", 32'h100, 1'b0);
        check_perf("sat");

        // Stalled mispredicted bne at 0x304 (idx 1).
        if_pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 3'd2, 32'h304, 32'd1, 32'd2, 32'h400, 1'b0);
            check($sformatf("stall%0d.redirect", i), 64'(redirect), 64'd0);
            tick(1'b0, 1'b0);
            check_perf($sformatf("stall%0d", i));
            check($sformatf("stall%0d.pred", i), 64'(if_pred_taken), 64'd0);
        end
        drive(1'b1, 1'b0, 3'd2, 32'h304, 32'd1, 32'd2, 32'h400, 1'b0);
        check("unstall.redirect", 64'(redirect), 64'd1);
        check("unstall.rpc", 64'(redirect_pc), 64'h400);
        tick(1'b1, 1'b1);
        check_perf("unstall");
        check("unstall.pred", 64'(if_pred_taken), 64'd1);

        // Bubble with a beq that would otherwise be not-taken.
        drive(1'b0, 1'b0, 3'd1, 32'h304, 32'd1, 32'd2, 32'h400, 1'b1);
        check("bubble.taken", 64'(br_taken), 64'd0);
        check("bubble.redirect", 64'(redirect), 64'd0);
        tick(1'b0, 1'b0);
        check_perf("bubble");
        check("bubble.pred", 64'(if_pred_taken), 64'd1);

        // JAL at 0x308 (idx 2): redirects but leaves the counter at weak-NT.
        if_pc = 32'h308;
        drive(1'b1, 1'b0, 3'd7, 32'h308, 32'd0, 32'd0, 32'h5000, 1'b0);
        check("jal.redirect", 64'(redirect), 64'd1);
        check("jal.rpc", 64'(redirect_pc), 64'h5000);
        tick(1'b1, 1'b1);
        check("jal.pred", 64'(if_pred_taken), 64'd0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
        check("perfsat.mispredicts", 64'(perf_mispredicts), 64'd15);
        check("perfsat.branches", 64'(perf_branches), 64'd15);
        check("jal.pred_after", 64'(if_pred_taken), 64'd0);

        // Reset concurrent with a taken beq at 0x304: update discarded.
        if_pc = 32'h304;
        drive(1'b1, 1'b0, 3'd1, 32'h304, 32'd3, 32'd3, 32'h400, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_br  = 0;
        m_mis = 0;
        idle();
        check_perf("midrst");
        check("midrst.pred", 64'(if_pred_taken), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
